// File: rtl/eq2_bwd.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : eq2_bwd
// Brief    : Gradient unit for the eq2 activation: grad_out = slope(X) * G,
//            2-stage elastic valid/ready pipeline with per-frame active count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module eq2_bwd #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   x_in,
   input  logic [WIDTH-1:0]     g_in,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   grad_out,
   output logic                 out_last,
   output logic [CNT_W-1:0]     active_cnt,
   output logic                 cnt_valid
);

   localparam int                  c_xw      = 2 * WIDTH;
   localparam int                  c_k_int   = 2 * WIDTH - 1;
   localparam logic [c_xw-1:0]     c_k       = c_k_int[c_xw-1:0];
   localparam logic [CNT_W-1:0]    c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic                r_rdy_en;
   logic                r_s1_v;
   logic [2:0]          r_s1_slope;
   logic [WIDTH-1:0]    r_s1_g;
   logic                r_s1_last;
   logic                r_s2_v;
   logic                r_s2_act;
   logic [c_xw-1:0]     r_grad;
   logic                r_last;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_active_cnt;
   logic                r_cnt_valid;

   logic [c_xw-1:0]     w_xp;
   logic [c_xw-1:0]     w_xm;
   logic [2:0]          w_sgn_p;
   logic [2:0]          w_sgn_m;
   logic [2:0]          w_slope;
   logic [c_xw-1:0]     w_gx;
   logic [c_xw-1:0]     w_prod;
   logic                w_s2_free;
   logic                w_s1_free;
   logic                w_in_hs;
   logic                w_out_hs;
   logic [CNT_W-1:0]    w_cnt_next;

   // Each sign term is 111 (-1), 001 (+1) or 000 (0); their 3-bit sum spans -2..+2.
   assign w_xp    = x_in + c_k;
   assign w_xm    = x_in - c_k;
   assign w_sgn_p = {3{w_xp[c_xw-1]}} | {2'b00, |w_xp};
   assign w_sgn_m = {3{w_xm[c_xw-1]}} | {2'b00, |w_xm};
   assign w_slope = w_sgn_p + w_sgn_m;

   assign w_gx = {{WIDTH{r_s1_g[WIDTH-1]}}, r_s1_g};

   always_comb begin
      w_prod = '0;
      case (r_s1_slope)
         3'b001:  w_prod = w_gx;
         3'b010:  w_prod = {w_gx[c_xw-2:0], 1'b0};
         3'b111:  w_prod = -w_gx;
         3'b110:  w_prod = -{w_gx[c_xw-2:0], 1'b0};
         default: w_prod = '0;
      endcase
   end

   assign w_s2_free = !r_s2_v || out_ready;
   assign w_s1_free = !r_s1_v || w_s2_free;
   assign in_ready  = r_rdy_en && w_s1_free;
   assign w_in_hs   = in_valid && in_ready;
   assign w_out_hs  = r_s2_v && out_ready;

   assign w_cnt_next = (r_s2_act && (r_cnt != c_cnt_max)) ? r_cnt + c_cnt_one : r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy_en   <= 1'b0;
         r_s1_v     <= 1'b0;
         r_s1_slope <= '0;
         r_s1_g     <= '0;
         r_s1_last  <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_s1_free) begin
            r_s1_v <= w_in_hs;
         end
         if (w_in_hs) begin
            r_s1_slope <= w_slope;
            r_s1_g     <= g_in;
            r_s1_last  <= in_last;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v   <= 1'b0;
         r_s2_act <= 1'b0;
         r_grad   <= '0;
         r_last   <= 1'b0;
      end else if (w_s2_free) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_act <= (r_s1_slope != 3'b000);
            r_grad   <= w_prod;
            r_last   <= r_s1_last;
         end
      end
   end

   // The closing beat of a frame publishes the count including itself and restarts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_active_cnt <= '0;
         r_cnt_valid  <= 1'b0;
      end else begin
         r_cnt_valid <= 1'b0;
         if (w_out_hs) begin
            if (r_last) begin
               r_active_cnt <= w_cnt_next;
               r_cnt_valid  <= 1'b1;
               r_cnt        <= '0;
            end else begin
               r_cnt <= w_cnt_next;
            end
         end
      end
   end

   assign out_valid  = r_s2_v;
   assign grad_out   = r_grad;
   assign out_last   = r_last;
   assign active_cnt = r_active_cnt;
   assign cnt_valid  = r_cnt_valid;

endmodule
`default_nettype wire
